// File: rtl/cam_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : cam_init_seq
// Description : Camera bring-up sequencer (clk_100 domain).
//               Power-cycles the camera through pwrup_o, waits for supply and
//               sensor start-up, fires one trigger at the I2C register writer
//               and waits for its completion pulse. A missing completion
//               causes a power-cycle and retry, up to MAX_RETRIES extra
//               attempts. The final outcome is reported on ready_o / fail_o.
//
// Ports       : clk_i        system clock (clk_100)
//               rst_i        synchronous active-high reset
//               start_i      request (re)initialisation, sampled every cycle
//               done_i       one-cycle completion pulse from the I2C writer
//               trig_o       one-cycle trigger pulse to the I2C writer
//               pwrup_o      camera power enable
//               busy_o       sequence in progress
//               ready_o      camera configured
//               fail_o       all attempts timed out
//               retry_cnt_o  retries consumed in the current sequence
//
// Revision    : 1.0 - initial release
// ============================================================================
module cam_init_seq #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned PWRDN_US    = 1000,
    parameter int unsigned PWRUP_US    = 20000,
    parameter int unsigned TIMEOUT_US  = 50000,
    parameter int unsigned SETTLE_US   = 1000,
    parameter int unsigned MAX_RETRIES = 3,
    localparam int unsigned RETRY_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               done_i,
    output logic               trig_o,
    output logic               pwrup_o,
    output logic               busy_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    // ------------------------------------------------------------------------
    // Cycle counts derived from the microsecond timings
    // ------------------------------------------------------------------------
    localparam int unsigned c_clk_mhz   = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned c_n_pwrdn   = c_clk_mhz * PWRDN_US;
    localparam int unsigned c_n_pwrup   = c_clk_mhz * PWRUP_US;
    localparam int unsigned c_n_timeout = c_clk_mhz * TIMEOUT_US;
    localparam int unsigned c_n_settle  = c_clk_mhz * SETTLE_US;

    localparam int unsigned c_n_max_a = (c_n_pwrdn   > c_n_pwrup)  ? c_n_pwrdn   : c_n_pwrup;
    localparam int unsigned c_n_max_b = (c_n_timeout > c_n_settle) ? c_n_timeout : c_n_settle;
    localparam int unsigned c_n_max   = (c_n_max_a   > c_n_max_b)  ? c_n_max_a   : c_n_max_b;

    // The counter is loaded with N-1 and runs down to 0, so it only has to
    // hold values up to c_n_max-1.
    localparam int unsigned c_cnt_w = (c_n_max > 1) ? $clog2(c_n_max) : 1;

    localparam logic [c_cnt_w-1:0] c_ld_pwrdn   = c_cnt_w'(c_n_pwrdn   - 1);
    localparam logic [c_cnt_w-1:0] c_ld_pwrup   = c_cnt_w'(c_n_pwrup   - 1);
    localparam logic [c_cnt_w-1:0] c_ld_timeout = c_cnt_w'(c_n_timeout - 1);
    localparam logic [c_cnt_w-1:0] c_ld_settle  = c_cnt_w'(c_n_settle  - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    localparam logic [RETRY_W-1:0] c_max_retries = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] c_retry_one   = RETRY_W'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time sanity checks on the timing parameters
    // ------------------------------------------------------------------------
    generate
        if ((CLK_FREQ_HZ % 1_000_000) != 0 || CLK_FREQ_HZ == 0) begin : g_bad_clk
            $error("cam_init_seq: CLK_FREQ_HZ must be a non-zero multiple of 1 MHz");
        end
        if (PWRDN_US == 0 || PWRUP_US == 0 || TIMEOUT_US == 0 || SETTLE_US == 0) begin : g_bad_time
            $error("cam_init_seq: all *_US timings must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PWR_OFF     = 3'd1,
        ST_PWR_ON_WAIT = 3'd2,
        ST_TRIG        = 3'd3,
        ST_WAIT_DONE   = 3'd4,
        ST_SETTLE      = 3'd5,
        ST_READY       = 3'd6,
        ST_FAIL        = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [RETRY_W-1:0]   r_retry;
    logic [RETRY_W-1:0]   w_retry_next;
    logic                 w_cnt_zero;

    // Registered outputs and their next values
    logic r_trig;
    logic r_pwrup;
    logic r_busy;
    logic r_ready;
    logic r_fail;
    logic w_trig_next;
    logic w_pwrup_next;
    logic w_busy_next;
    logic w_ready_next;
    logic w_fail_next;

    assign w_cnt_zero = (r_cnt == '0);

    // State, counter and retry registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_retry <= w_retry_next;
        end
    end

    // Next-state, counter and retry logic. Every timed state is entered with
    // the counter preloaded to N-1, so the state lasts exactly N cycles and
    // leaves on the cycle the counter reads zero.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_retry_next = r_retry;

        case (r_state)
            ST_IDLE: begin
                w_retry_next = '0;
                if (start_i) begin
                    w_state_next = ST_PWR_OFF;
                    w_cnt_next   = c_ld_pwrdn;
                end
            end

            ST_PWR_OFF: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_PWR_ON_WAIT;
                    w_cnt_next   = c_ld_pwrup;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end

            ST_PWR_ON_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_TRIG;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end

            ST_TRIG: begin
                w_state_next = ST_WAIT_DONE;
                w_cnt_next   = c_ld_timeout;
            end

            ST_WAIT_DONE: begin
                // Completion is checked before expiry so that a pulse landing
                // on the final timeout cycle still counts as success.
                if (done_i) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = c_ld_settle;
                end else if (w_cnt_zero) begin
                    if (r_retry < c_max_retries) begin
                        w_retry_next = r_retry + c_retry_one;
                        w_state_next = ST_PWR_OFF;
                        w_cnt_next   = c_ld_pwrdn;
                    end else begin
                        w_state_next = ST_FAIL;
                    end
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end

            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_next = ST_READY;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_one;
                end
            end

            ST_READY, ST_FAIL: begin
                // The retry count is held for inspection until a new request.
                if (start_i) begin
                    w_state_next = ST_PWR_OFF;
                    w_cnt_next   = c_ld_pwrdn;
                    w_retry_next = '0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_retry_next = '0;
            end
        endcase
    end

    // Output decode from the next state; the result is registered so the
    // outputs line up with the state they describe and are glitch-free.
    always_comb begin
        w_trig_next  = 1'b0;
        w_pwrup_next = 1'b0;
        w_busy_next  = 1'b0;
        w_ready_next = 1'b0;
        w_fail_next  = 1'b0;

        case (w_state_next)
            ST_PWR_OFF: begin
                w_busy_next = 1'b1;
            end
            ST_PWR_ON_WAIT, ST_WAIT_DONE, ST_SETTLE: begin
                w_busy_next  = 1'b1;
                w_pwrup_next = 1'b1;
            end
            ST_TRIG: begin
                w_busy_next  = 1'b1;
                w_pwrup_next = 1'b1;
                w_trig_next  = 1'b1;
            end
            ST_READY: begin
                w_ready_next = 1'b1;
                w_pwrup_next = 1'b1;
            end
            ST_FAIL: begin
                w_fail_next = 1'b1;
            end
            default: begin
                w_trig_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_trig  <= 1'b0;
            r_pwrup <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_trig  <= w_trig_next;
            r_pwrup <= w_pwrup_next;
            r_busy  <= w_busy_next;
            r_ready <= w_ready_next;
            r_fail  <= w_fail_next;
        end
    end

    assign trig_o      = r_trig;
    assign pwrup_o     = r_pwrup;
    assign busy_o      = r_busy;
    assign ready_o     = r_ready;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_cam_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_init_seq
// Description : Self-checking bench for cam_init_seq. Directed scenarios are
//               checked against a table of expected output snapshots and,
//               every cycle, against a timeline-based reference model; a
//               randomized phase then exercises the model comparison alone.
//               Output vector layout: {trig, pwrup, busy, ready, fail, retry[1:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_init_seq;

    localparam int NP = 4;
    localparam int NU = 10;
    localparam int NT = 20;
    localparam int NS = 3;
    localparam int MR = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       done_i;
    logic       trig_o;
    logic       pwrup_o;
    logic       busy_o;
    logic       ready_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;

    always #5 clk_i = ~clk_i;

    cam_init_seq #(
        .CLK_FREQ_HZ (1_000_000),
        .PWRDN_US    (NP),
        .PWRUP_US    (NU),
        .TIMEOUT_US  (NT),
        .SETTLE_US   (NS),
        .MAX_RETRIES (MR)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .done_i      (done_i),
        .trig_o      (trig_o),
        .pwrup_o     (pwrup_o),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o)
    );

    logic [6:0] act;
    assign act = {trig_o, pwrup_o, busy_o, ready_o, fail_o, retry_cnt_o};

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------------
    // Directed scenario inputs and expected-output table
    // ------------------------------------------------------------------------
    typedef struct {
        int len;
        int s0; int s1; int s2;
        int d0; int d1;
        int rc;
    } scen_t;

    typedef struct {
        int         sid;
        int         cyc;
        logic [6:0] exp;
    } vec_t;

    scen_t scens[7];
    vec_t  vecs[$];

    function automatic void add_vec(int sid, int cyc, logic [6:0] e);
        vec_t v;
        v.sid = sid;
        v.cyc = cyc;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic scen_t mk_scen(int len, int s0, int s1, int s2, int d0, int d1, int rc);
        scen_t s;
        s.len = len; s.s0 = s0; s.s1 = s1; s.s2 = s2;
        s.d0 = d0; s.d1 = d1; s.rc = rc;
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: tracks when the current attempt began and when
    // completion arrived, and derives the outputs from elapsed time.
    // ------------------------------------------------------------------------
    localparam int K_IDLE  = 0;
    localparam int K_SEQ   = 1;
    localparam int K_READY = 2;
    localparam int K_FAIL  = 3;

    int m_kind;
    int m_t0;
    int m_dn;
    int m_ret;
    int g_cyc = 0;

    function automatic void model_reset();
        m_kind = K_IDLE;
        m_t0   = 0;
        m_dn   = -1;
        m_ret  = 0;
    endfunction

    function automatic logic [6:0] model_out();
        logic t, p, b, r, f;
        int   off;
        t = 1'b0; p = 1'b0; b = 1'b0; r = 1'b0; f = 1'b0;
        case (m_kind)
            K_SEQ: begin
                b = 1'b1;
                if (m_dn >= 0) begin
                    p = 1'b1;
                end else begin
                    off = g_cyc - m_t0;
                    p = (off >= NP);
                    t = (off == NP + NU);
                end
            end
            K_READY: begin p = 1'b1; r = 1'b1; end
            K_FAIL:  f = 1'b1;
            default: ;
        endcase
        return {t, p, b, r, f, 2'(m_ret)};
    endfunction

    // Advance from the current cycle to the next given this cycle's inputs.
    function automatic void model_step(logic st, logic dn, logic rs);
        int off;
        if (rs) begin
            model_reset();
        end else begin
            case (m_kind)
                K_IDLE, K_READY, K_FAIL: begin
                    if (st) begin
                        m_kind = K_SEQ;
                        m_t0   = g_cyc + 1;
                        m_dn   = -1;
                        m_ret  = 0;
                    end
                end
                default: begin
                    if (m_dn >= 0) begin
                        if (g_cyc == m_dn + NS) m_kind = K_READY;
                    end else begin
                        off = g_cyc - m_t0;
                        if (off > NP + NU) begin
                            if (dn) begin
                                m_dn = g_cyc;
                            end else if (off == NP + NU + NT) begin
                                if (m_ret < MR) begin
                                    m_ret = m_ret + 1;
                                    m_t0  = g_cyc + 1;
                                end else begin
                                    m_kind = K_FAIL;
                                end
                            end
                        end
                    end
                end
            endcase
        end
        g_cyc = g_cyc + 1;
    endfunction

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic check_model(string tag, int c);
        logic [6:0] e;
        e = model_out();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL model %s cyc=%0d got=%b exp=%b", tag, c, act, e);
        end
    endtask

    task automatic check_table(int sid, int c);
        foreach (vecs[i]) begin
            if (vecs[i].sid == sid && vecs[i].cyc == c) begin
                n_tests++;
                if (act !== vecs[i].exp) begin
                    n_fail++;
                    $display("FAIL table s%0d cyc=%0d got=%b exp=%b", sid, c, act, vecs[i].exp);
                end
            end
        end
    endtask

    // One reset cycle, then the scenario timeline. On entry and exit the
    // bench sits 1 time unit after a rising edge.
    task automatic run_scen(int sid);
        scen_t s;
        s = scens[sid];
        rst_i = 1'b1; start_i = 1'b0; done_i = 1'b0;
        model_step(1'b0, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int c = 0; c < s.len; c++) begin
            check_model($sformatf("s%0d", sid), c);
            check_table(sid, c);
            start_i = (c == s.s0) || (c == s.s1) || (c == s.s2);
            done_i  = (c == s.d0) || (c == s.d1);
            rst_i   = (c == s.rc);
            model_step(start_i, done_i, rst_i);
            @(posedge clk_i); #1;
        end
        start_i = 1'b0; done_i = 1'b0; rst_i = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        // len, start x3, done x2, reset cycle (-1 = none)
        scens[0] = mk_scen( 30,  0, -1, -1, 20, -1, -1);  // nominal
        scens[1] = mk_scen( 65,  0, -1, -1, 55, -1, -1);  // single retry
        scens[2] = mk_scen(115,  0, -1, -1, -1, -1, -1);  // exhaustion
        scens[3] = mk_scen( 45,  0, -1, -1, 35, -1, -1);  // done on expiry cycle
        scens[4] = mk_scen( 50,  0, 30, -1, 20, -1, 18);  // reset mid-sequence
        scens[5] = mk_scen( 56,  0,  8, 30, 20, 48, -1);  // ignored start, re-init
        scens[6] = mk_scen(  8, -1, -1, -1,  3, -1, -1);  // done while idle

        //            sid cyc  {trig,pwr,busy,rdy,fail,retry}
        add_vec(0,  0, 7'b0_0_0_0_0_00);
        add_vec(0,  1, 7'b0_0_1_0_0_00);
        add_vec(0,  4, 7'b0_0_1_0_0_00);
        add_vec(0,  5, 7'b0_1_1_0_0_00);
        add_vec(0, 14, 7'b0_1_1_0_0_00);
        add_vec(0, 15, 7'b1_1_1_0_0_00);
        add_vec(0, 16, 7'b0_1_1_0_0_00);
        add_vec(0, 23, 7'b0_1_1_0_0_00);
        add_vec(0, 24, 7'b0_1_0_1_0_00);
        add_vec(0, 29, 7'b0_1_0_1_0_00);

        add_vec(1, 35, 7'b0_1_1_0_0_00);
        add_vec(1, 36, 7'b0_0_1_0_0_01);
        add_vec(1, 39, 7'b0_0_1_0_0_01);
        add_vec(1, 40, 7'b0_1_1_0_0_01);
        add_vec(1, 50, 7'b1_1_1_0_0_01);
        add_vec(1, 58, 7'b0_1_1_0_0_01);
        add_vec(1, 59, 7'b0_1_0_1_0_01);

        add_vec(2, 15, 7'b1_1_1_0_0_00);
        add_vec(2, 50, 7'b1_1_1_0_0_01);
        add_vec(2, 85, 7'b1_1_1_0_0_10);
        add_vec(2,105, 7'b0_1_1_0_0_10);
        add_vec(2,106, 7'b0_0_0_0_1_10);
        add_vec(2,114, 7'b0_0_0_0_1_10);

        add_vec(3, 35, 7'b0_1_1_0_0_00);
        add_vec(3, 36, 7'b0_1_1_0_0_00);
        add_vec(3, 38, 7'b0_1_1_0_0_00);
        add_vec(3, 39, 7'b0_1_0_1_0_00);

        add_vec(4, 18, 7'b0_1_1_0_0_00);
        add_vec(4, 19, 7'b0_0_0_0_0_00);
        add_vec(4, 21, 7'b0_0_0_0_0_00);
        add_vec(4, 30, 7'b0_0_0_0_0_00);
        add_vec(4, 31, 7'b0_0_1_0_0_00);
        add_vec(4, 45, 7'b1_1_1_0_0_00);

        add_vec(5,  9, 7'b0_1_1_0_0_00);
        add_vec(5, 15, 7'b1_1_1_0_0_00);
        add_vec(5, 30, 7'b0_1_0_1_0_00);
        add_vec(5, 31, 7'b0_0_1_0_0_00);
        add_vec(5, 34, 7'b0_0_1_0_0_00);
        add_vec(5, 35, 7'b0_1_1_0_0_00);
        add_vec(5, 45, 7'b1_1_1_0_0_00);
        add_vec(5, 52, 7'b0_1_0_1_0_00);

        add_vec(6,  4, 7'b0_0_0_0_0_00);
        add_vec(6,  7, 7'b0_0_0_0_0_00);

        // Power-on reset
        rst_i = 1'b1; start_i = 1'b0; done_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;

        for (int sid = 0; sid < 7; sid++) begin
            run_scen(sid);
        end

        // Randomized traffic checked against the model every cycle
        rst_i = 1'b1;
        model_step(1'b0, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check_model("rand", c);
            start_i = ($urandom_range(0, 19) == 0);
            done_i  = ($urandom_range(0, 29) == 0);
            rst_i   = ($urandom_range(0, 499) == 0);
            model_step(start_i, done_i, rst_i);
            @(posedge clk_i); #1;
        end
        start_i = 1'b0; done_i = 1'b0; rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
